// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving a single-port S-box RAM.
// Optional identity fill, then one KSA swap pass; i==j swaps are skipped.
module ksa_engine #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   init_en,
    input  logic                   abort,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [ADDR_W-1:0]      data_read,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W-1:0]      data,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);
    localparam logic [LW-1:0]     L_LAST = LW'(RD_LAT - 1);
    localparam logic [ADDR_W:0]   I_ONE  = (ADDR_W + 1)'(1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT_WR = 4'd1;
    localparam logic [3:0] S_RD_I    = 4'd2;
    localparam logic [3:0] S_WAIT_I  = 4'd3;
    localparam logic [3:0] S_CAP_I   = 4'd4;
    localparam logic [3:0] S_SKIP    = 4'd5;
    localparam logic [3:0] S_RD_J    = 4'd6;
    localparam logic [3:0] S_WAIT_J  = 4'd7;
    localparam logic [3:0] S_CAP_J   = 4'd8;
    localparam logic [3:0] S_WR_I    = 4'd9;
    localparam logic [3:0] S_WR_J    = 4'd10;
    localparam logic [3:0] S_DONE    = 4'd11;

    logic [3:0]             state_q, state_d;
    logic [ADDR_W:0]        i_q, i_d;
    logic [ADDR_W-1:0]      j_q, j_d;
    logic [ADDR_W-1:0]      si_q, si_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      data_q, data_d;
    logic [KW-1:0]          k_q, k_d;
    logic [LW-1:0]          lat_q, lat_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic                   wren_q, wren_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [7:0]        key_byte8;
    logic [ADDR_W-1:0] key_byte;
    logic [ADDR_W-1:0] j_sum;
    logic [ADDR_W:0]   i_inc;
    logic [KW-1:0]     k_inc;
    logic              run_state;
    logic              advance;

    always_comb begin
        key_byte8 = '0;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KW'(b)) key_byte8 = key_q[8*(KEY_BYTES-b)-1 -: 8];
        end
        key_byte  = ADDR_W'(key_byte8);
        j_sum     = j_q + data_read + key_byte;
        i_inc     = i_q + I_ONE;
        k_inc     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
        run_state = (state_q != S_IDLE) && (state_q != S_DONE);
    end

    // Outputs are registered with the values of the state being entered,
    // so address/data/wren on the ports always describe the current state.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        lat_d   = lat_q;
        key_d   = key_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    key_d  = key;
                    i_d    = '0;
                    j_d    = '0;
                    k_d    = '0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    addr_d = '0;
                    if (init_en) begin
                        state_d = S_INIT_WR;
                        data_d  = '0;
                        wren_d  = 1'b1;
                    end else begin
                        state_d = S_RD_I;
                    end
                end
            end
            S_INIT_WR: begin
                if (i_inc[ADDR_W]) begin
                    i_d     = '0;
                    addr_d  = '0;
                    state_d = S_RD_I;
                end else begin
                    i_d    = i_inc;
                    addr_d = i_inc[ADDR_W-1:0];
                    data_d = i_inc[ADDR_W-1:0];
                    wren_d = 1'b1;
                end
            end
            S_RD_I: begin
                lat_d   = '0;
                state_d = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (lat_q == L_LAST) state_d = S_CAP_I;
                else                 lat_d   = lat_q + LW'(1);
            end
            S_CAP_I: begin
                si_d = data_read;
                j_d  = j_sum;
                if (j_sum == i_q[ADDR_W-1:0]) begin
                    state_d = S_SKIP;
                end else begin
                    addr_d  = j_sum;
                    state_d = S_RD_J;
                end
            end
            S_SKIP: advance = 1'b1;
            S_RD_J: begin
                lat_d   = '0;
                state_d = S_WAIT_J;
            end
            S_WAIT_J: begin
                if (lat_q == L_LAST) state_d = S_CAP_J;
                else                 lat_d   = lat_q + LW'(1);
            end
            S_CAP_J: begin
                addr_d  = i_q[ADDR_W-1:0];
                data_d  = data_read;
                wren_d  = 1'b1;
                state_d = S_WR_I;
            end
            S_WR_I: begin
                addr_d  = j_q;
                data_d  = si_q;
                wren_d  = 1'b1;
                state_d = S_WR_J;
            end
            S_WR_J: advance = 1'b1;
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (advance) begin
            k_d = k_inc;
            if (i_inc[ADDR_W]) begin
                i_d     = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                i_d     = i_inc;
                addr_d  = i_inc[ADDR_W-1:0];
                state_d = S_RD_I;
            end
        end

        // Abort only cancels what follows; a write already on the port completes.
        if (abort && run_state) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            data_d  = data_q;
            wren_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            lat_q   <= '0;
            key_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            lat_q   <= lat_d;
            key_q   <= key_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign address = addr_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine: directed checks of ksa_engine against a software RC4 KSA
// model, using two configurations each attached to a latency-accurate RAM.
module tb_ksa_engine;
    localparam int A_LAT = 2;
    localparam int B_LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, init_a = 1'b0, abort_a = 1'b0;
    logic [23:0] key_a = '0;
    logic [7:0]  dr_a, addr_a, data_a;
    logic        wren_a, busy_a, done_a;

    logic        start_b = 1'b0, init_b = 1'b0, abort_b = 1'b0;
    logic [7:0]  key_b = '0;
    logic [3:0]  dr_b, addr_b, data_b;
    logic        wren_b, busy_b, done_b;

    ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(A_LAT)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .init_en(init_a),
        .abort(abort_a), .key(key_a), .data_read(dr_a), .address(addr_a),
        .data(data_a), .wren(wren_a), .busy(busy_a), .done(done_a));

    ksa_engine #(.ADDR_W(4), .KEY_BYTES(1), .RD_LAT(B_LAT)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .init_en(init_b),
        .abort(abort_b), .key(key_b), .data_read(dr_b), .address(addr_b),
        .data(data_b), .wren(wren_b), .busy(busy_b), .done(done_b));

    function automatic int pat(input int mode, input int n, input int size);
        if (mode == 1) return size - 1 - n;
        return (n ^ 'hA5) & (size - 1);
    endfunction

    // RAMs: registered read pipeline of RD_LAT stages, write on wren
    int         ld_a = 0, ld_b = 0;
    logic [7:0] mem_a [256];
    logic [7:0] pipe_a [A_LAT];
    logic [3:0] mem_b [16];
    logic [3:0] pipe_b [B_LAT];

    always @(posedge clk) begin
        if (ld_a != 0) for (int n = 0; n < 256; n++) mem_a[n] <= 8'(pat(ld_a, n, 256));
        else if (wren_a) mem_a[addr_a] <= data_a;
        pipe_a[0] <= mem_a[addr_a];
        for (int s = 1; s < A_LAT; s++) pipe_a[s] <= pipe_a[s-1];
    end
    assign dr_a = pipe_a[A_LAT-1];

    always @(posedge clk) begin
        if (ld_b != 0) for (int n = 0; n < 16; n++) mem_b[n] <= 4'(pat(ld_b, n, 16));
        else if (wren_b) mem_b[addr_b] <= data_b;
        pipe_b[0] <= mem_b[addr_b];
    end
    assign dr_b = pipe_b[B_LAT-1];

    int   bc_a = 0, wr_a = 0, rise_a = 0, bc_b = 0, wr_b = 0, rise_b = 0;
    logic dp_a = 1'b0, dp_b = 1'b0;
    int   wbc_a[$], wad_a[$], wdt_a[$], wbc_b[$], wad_b[$], wdt_b[$];

    always @(negedge clk) begin
        if (wren_a) begin
            wbc_a.push_back(bc_a); wad_a.push_back(int'(addr_a)); wdt_a.push_back(int'(data_a));
            wr_a = wr_a + 1;
        end
        if (busy_a) bc_a = bc_a + 1;
        if (done_a && !dp_a) rise_a = rise_a + 1;
        dp_a = done_a;
        if (wren_b) begin
            wbc_b.push_back(bc_b); wad_b.push_back(int'(addr_b)); wdt_b.push_back(int'(data_b));
            wr_b = wr_b + 1;
        end
        if (busy_b) bc_b = bc_b + 1;
        if (done_b && !dp_b) rise_b = rise_b + 1;
        dp_b = done_b;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Software RC4 KSA over a seeded S-box, recording per-iteration timing
    int mdl[256];
    bit mskip[256];
    int mstart[256];
    int mcyc, mnorm;
    task automatic model(input int aw, input int nkb, input int lat, input logic [23:0] k,
                         input logic ie, input int ld, input int iters);
        int sz, j, t, kb;
        sz = 1 << aw;
        j = 0;
        for (int x = 0; x < sz; x++) mdl[x] = ie ? x : pat(ld, x, sz);
        mcyc = ie ? sz : 0;
        mnorm = 0;
        for (int i = 0; i < iters; i++) begin
            mstart[i] = mcyc;
            kb = int'((k >> (8 * (nkb - 1 - (i % nkb)))) & 24'hFF) & (sz - 1);
            j = (j + mdl[i] + kb) & (sz - 1);
            mskip[i] = (j == i);
            if (j == i) mcyc += lat + 3;
            else begin
                t = mdl[i]; mdl[i] = mdl[j]; mdl[j] = t;
                mcyc += 2 * lat + 6;
                mnorm++;
            end
        end
    endtask

    int ba_bc, ba_wr, ba_rise, bb_bc, bb_wr, bb_rise;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_a(input logic [23:0] k, input logic ie, input int ld, input int poke,
                         input int ab, input int rs, output int ncyc, output int fin);
        ba_bc = bc_a; ba_wr = wr_a; ba_rise = rise_a;
        ld_a = ld; tick(); ld_a = 0;
        start_a = 1'b1; init_a = ie; key_a = k;
        tick();
        start_a = 1'b0;
        fin = 0;
        for (int n = 0; n < 6000 && fin == 0; n++) begin
            start_a = (n == poke);
            abort_a = (n == ab);
            reset   = (n == rs);
            key_a   = (n == 0) ? k : k ^ 24'(n * 40503);
            init_a  = ~ie;
            @(negedge clk); #1;
            if (done_a) fin = 1;
            else if (n == ab || n == rs) fin = 2;
            else tick();
        end
        if (fin == 2) tick();
        start_a = 1'b0; abort_a = 1'b0; reset = 1'b0;
        ncyc = bc_a - ba_bc;
    endtask

    task automatic check_ram_a(input string name);
        int bad = 0;
        for (int x = 0; x < 256; x++) if (mem_a[x] != 8'(mdl[x])) bad++;
        chk(name, bad, 0);
    endtask

    typedef struct {
        logic [23:0] key;
        logic        ie;
        int          ld;
        int          poke;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int nc, fin, ia, nbad, idx;
        vecs[0] = '{24'h000249, 1'b1, 2, -1};
        vecs[1] = '{24'h000000, 1'b1, 1, -1};
        vecs[2] = '{24'hFFFFFF, 1'b1, 2, -1};
        vecs[3] = '{24'h0A0B0C, 1'b0, 1, -1};
        vecs[4] = '{24'h000249, 1'b1, 1, 50};
        vecs[5] = '{24'h5A3C96, 1'b0, 2, -1};

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_addr_a", int'(addr_a), 0);
        chk("rst_data_a", int'(data_a), 0);
        chk("rst_wren_a", int'(wren_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_done_a", int'(done_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_done_b", int'(done_b), 0);

        for (int v = 0; v < 6; v++) begin
            model(8, 3, A_LAT, vecs[v].key, vecs[v].ie, vecs[v].ld, 256);
            run_a(vecs[v].key, vecs[v].ie, vecs[v].ld, vecs[v].poke, -1, -1, nc, fin);
            chk($sformatf("v%0d_done_seen", v), fin, 1);
            chk($sformatf("v%0d_busy_cycles", v), nc, mcyc);
            chk($sformatf("v%0d_writes", v), wr_a - ba_wr, (vecs[v].ie ? 256 : 0) + 2 * mnorm);
            repeat (3) tick();
            chk($sformatf("v%0d_done_rises", v), rise_a - ba_rise, 1);
            chk($sformatf("v%0d_busy_after", v), int'(busy_a), 0);
            chk($sformatf("v%0d_done_level", v), int'(done_a), 1);
            check_ram_a($sformatf("v%0d_ram", v));
        end

        // start together with abort while DONE: abort wins, start ignored
        start_a = 1'b1; abort_a = 1'b1; key_a = 24'h111111; init_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk); #1;
        chk("abort_start_busy", int'(busy_a), 0);
        chk("abort_start_done", int'(done_a), 1);
        chk("abort_start_wren", int'(wren_a), 0);

        // all-zero key: iterations 0 and 1 skip (5 cycles each), i=2 swaps S[2],S[3]
        model(8, 3, A_LAT, 24'h000000, 1'b1, 2, 256);
        run_a(24'h000000, 1'b1, 2, -1, -1, -1, nc, fin);
        idx = ba_wr + 256;
        chk("k0_done_seen", fin, 1);
        chk("k0_wr0_cycle", (wbc_a.size() > idx) ? wbc_a[idx] - ba_bc : -1, 274);
        chk("k0_wr0_addr", (wad_a.size() > idx) ? wad_a[idx] : -1, 2);
        chk("k0_wr0_data", (wdt_a.size() > idx) ? wdt_a[idx] : -1, 3);
        chk("k0_wr1_cycle", (wbc_a.size() > idx + 1) ? wbc_a[idx+1] - ba_bc : -1, 275);
        chk("k0_wr1_addr", (wad_a.size() > idx + 1) ? wad_a[idx+1] : -1, 3);
        chk("k0_wr1_data", (wdt_a.size() > idx + 1) ? wdt_a[idx+1] : -1, 2);

        // abort in the first WAIT_J cycle of the first swapping iteration at i>=100
        model(8, 3, A_LAT, 24'h000249, 1'b1, 2, 256);
        ia = 100;
        for (int i = 255; i >= 100; i--) if (!mskip[i]) ia = i;
        nc = mstart[ia] + A_LAT + 3;
        model(8, 3, A_LAT, 24'h000249, 1'b1, 2, ia);
        run_a(24'h000249, 1'b1, 2, -1, nc, -1, nc, fin);
        chk("abort_reached", fin, 2);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_wren", int'(wren_a), 0);
        chk("abort_done", int'(done_a), 0);
        nbad = wr_a;
        repeat (20) tick();
        chk("abort_no_more_wr", wr_a - nbad, 0);
        chk("abort_no_done", rise_a - ba_rise, 0);
        chk("abort_writes", wr_a - ba_wr, 256 + 2 * mnorm);
        check_ram_a("abort_ram");

        // reset while init is writing entry 40
        run_a(24'h000249, 1'b1, 2, -1, -1, 40, nc, fin);
        chk("rst_mid_reached", fin, 2);
        chk("rst_mid_addr", int'(addr_a), 0);
        chk("rst_mid_data", int'(data_a), 0);
        chk("rst_mid_wren", int'(wren_a), 0);
        chk("rst_mid_busy", int'(busy_a), 0);
        chk("rst_mid_done", int'(done_a), 0);
        repeat (5) tick();
        chk("rst_mid_no_done", rise_a - ba_rise, 0);
        chk("rst_mid_writes", wr_a - ba_wr, 41);
        chk("rst_mid_mem40", int'(mem_a[40]), 40);
        chk("rst_mid_mem41", int'(mem_a[41]), 41 ^ 'hA5);

        // small configuration: 16 entries, 1-byte key, 1-cycle read latency
        model(4, 1, B_LAT, 24'h00000B, 1'b1, 2, 16);
        bb_bc = bc_b; bb_wr = wr_b; bb_rise = rise_b;
        ld_b = 2; tick(); ld_b = 0;
        start_b = 1'b1; init_b = 1'b1; key_b = 8'h0B;
        tick();
        start_b = 1'b0;
        fin = 0;
        for (int n = 0; n < 2000 && fin == 0; n++) begin
            key_b = 8'h0B ^ 8'(n);
            @(negedge clk); #1;
            if (done_b) fin = 1;
            else tick();
        end
        nc = bc_b - bb_bc;
        chk("b_done_seen", fin, 1);
        chk("b_busy_cycles", nc, mcyc);
        chk("b_writes", wr_b - bb_wr, 16 + 2 * mnorm);
        idx = bb_wr + 16;
        chk("b_wr0_cycle", (wbc_b.size() > idx) ? wbc_b[idx] - bb_bc : -1, 22);
        chk("b_wr0_addr", (wad_b.size() > idx) ? wad_b[idx] : -1, 0);
        chk("b_wr0_data", (wdt_b.size() > idx) ? wdt_b[idx] : -1, 11);
        chk("b_wr1_addr", (wad_b.size() > idx + 1) ? wad_b[idx+1] : -1, 11);
        chk("b_wr2_cycle", (wbc_b.size() > idx + 2) ? wbc_b[idx+2] - bb_bc : -1, 30);
        chk("b_wr2_data", (wdt_b.size() > idx + 2) ? wdt_b[idx+2] : -1, 7);
        nbad = 0;
        for (int x = 0; x < 16; x++) if (mem_b[x] != 4'(mdl[x])) nbad++;
        chk("b_ram", nbad, 0);
        repeat (3) tick();
        chk("b_done_rises", rise_b - bb_rise, 1);
        chk("b_busy_after", int'(busy_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ksa_engine.md
Name: ksa_engine

Overview:
- Parametrised RC4 key-scheduling engine: optional S-box identity init (S[i]=i), then the full KSA swap pass over a single-port S-box RAM.
- Generalises the fixed 3-byte, 8-bit, fixed-latency swap loop. Adds configurable key length, address width and RAM read latency, plus an on-chip init phase, i==j swap skip, key latching, abort, and busy/done status.
- Sits between the top-level cracking controller (start/done) and the S-box working RAM.

Parameters:
- ADDR_W, 8, S-box index and data width; the S-box has 2^ADDR_W entries.
- KEY_BYTES, 3, key length in bytes (>=1); the key port is 8*KEY_BYTES bits wide.
- RD_LAT, 2, RAM read latency in cycles (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled in IDLE or DONE only.
- init_en  in  1  sampled with start; 1 = run the identity-init phase first.
- abort  in  1  synchronous abort of a run.
- key  in  8*KEY_BYTES  secret key; byte 0 is the most-significant byte.
- data_read  in  ADDR_W  RAM read data.
- address  out  ADDR_W  RAM address (registered).
- data  out  ADDR_W  RAM write data (registered).
- wren  out  1  RAM write enable (registered).
- busy  out  1  high from the cycle after start is accepted until DONE/IDLE.
- done  out  1  level; high in DONE until the next accepted start or reset.

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - State goes to IDLE.
  - address=0, data=0, wren=0, busy=0, done=0.
  - i, j, k, key_reg cleared.
  - Reset mid-run leaves RAM contents as-is; there is no rollback.
- Start acceptance:
  - start=1 in IDLE or DONE: latch key into key_reg and init_en into mode; set i=0, j=0, k=0, done=0.
  - Next state is INIT_WR if init_en=1, else RD_I.
  - start is ignored while busy. Changes on key after acceptance are ignored.
- INIT_WR (one cycle per entry):
  - address=i, data=i, wren=1, i++.
  - After the write of entry 2^ADDR_W-1: i=0 and go to RD_I.
- Swap loop states:
  - RD_I: address=i, wren=0.
  - WAIT_I: RD_LAT cycles.
  - CAP_I: si=data_read; j_next=(j+si+key_byte[k]) mod 2^ADDR_W; j=j_next.
    - If j_next==i: the swap is skipped; go to NEXT.
    - Else: go to RD_J.
  - RD_J: address=j, wren=0.
  - WAIT_J: RD_LAT cycles.
  - CAP_J: sj=data_read.
  - WR_I: address=i, data=sj, wren=1.
  - WR_J: address=j, data=si, wren=1.
  - NEXT (folded into the last cycle of the iteration, no extra cycle): wren deasserted by the following state.
    - i++; k=(k==KEY_BYTES-1)?0:k+1. k is a wrap counter; no modulo operator.
    - If i wrapped past 2^ADDR_W-1, go to DONE; else go to RD_I.
- Iteration length:
  - Normal iteration: 2*RD_LAT+6 cycles. Skipped iteration: RD_LAT+3 cycles.
  - wren is high only in INIT_WR, WR_I and WR_J.
- key_byte[k] = key_reg[8*(KEY_BYTES-k)-1 -: 8], zero-extended or truncated to ADDR_W.
- i, j and the sums wrap modulo 2^ADDR_W. i uses an ADDR_W+1-bit counter for terminal detection.
- DONE: wren=0, busy=0, done=1. Holds until start (restarts the run) or reset.
- abort=1 in any busy state:
  - Next cycle: state IDLE, wren=0, busy=0, done=0.
  - A write issued in the abort cycle completes; no further writes follow.
  - abort and start in the same cycle while in IDLE/DONE: abort wins and start is ignored.
- The S-box read is always issued before any write of the same iteration (read-before-write ordering within an iteration).

Test Plan:
- ADDR_W=8, KEY_BYTES=3, RD_LAT=2, init_en=1, key=24'h000249 -> final RAM matches the software RC4 KSA model for all 256 entries; done rises exactly once; busy low after.
- Same config, key=24'h000000, init_en=1 -> i=0 (j=0) and i=1 (j=1) are skipped with no wren during those iterations; iteration i=2 writes S[2]=3, S[3]=2; each skip lasts 5 cycles.
- Assert start again at the 50th cycle of busy with a different key -> ignored; final RAM still matches the original key; latched key unaffected by key changes mid-run.
- init_en=0 with the RAM preloaded to a reversed permutation -> no INIT_WR writes; result matches the model seeded with that permutation.
- Assert abort during WAIT_J at i=100 -> IDLE next cycle, no further wren, done=0. Assert reset mid-init at i=40 -> all outputs 0 next cycle and done stays 0.
- Re-parameterise ADDR_W=4, KEY_BYTES=1, RD_LAT=1, key=8'h0B -> 16-entry result matches the model; k stays 0; normal iteration length is 8 cycles.
